// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state type and default constants for the parametrised data memory.
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int DMEM_ADDR_W      = 6;
    localparam int DMEM_BLOCK_BYTES = 4;
    localparam int DMEM_LATENCY     = 5;
    localparam int DMEM_CNT_W       = 16;
    function automatic int cnt_width(input int latency);
        return latency > 1 ? $clog2(latency) : 1;
    endfunction
endpackage

// File: rtl/dmem_latency_counter.sv
// dmem_latency_counter: loadable down-counter that stops at zero and flags it.
module dmem_latency_counter #(
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         enable,
    input  logic [W-1:0] load_value,
    output logic         zero
);
    logic [W-1:0] count;
    assign zero = count == '0;
    always_ff @(posedge clock) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (enable && !zero)
            count <= count - 1'b1;
    end
endmodule

// File: rtl/param_data_memory.sv
// param_data_memory: block-wide multi-cycle main memory with read/write/busywait handshake.
// Optional read/write commit counters are built when DMEM_PERF_CNT_EN is defined.
module param_data_memory
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = DMEM_ADDR_W,
    parameter int BLOCK_BYTES = DMEM_BLOCK_BYTES,
    parameter int LATENCY     = DMEM_LATENCY
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     read,
    input  logic                     write,
    input  logic [ADDR_W-1:0]        address,
    input  logic [8*BLOCK_BYTES-1:0] writedata,
    output logic [8*BLOCK_BYTES-1:0] readdata,
    output logic                     busywait
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [DMEM_CNT_W-1:0]    read_count,
    output logic [DMEM_CNT_W-1:0]    write_count
`endif
);
    localparam int DW    = 8 * BLOCK_BYTES;
    localparam int CW    = cnt_width(LATENCY);
    localparam int DEPTH = 1 << ADDR_W;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [DW-1:0]     data_q;
    logic              is_write_q;
    logic              zero;
    logic              valid;
    logic              commit;
    // Each entry is one block; byte i sits at bits [8i+7:8i], i.e. byte address {address, i}.
    logic [DW-1:0]     mem [DEPTH];

    assign valid    = read ^ write;
    assign commit   = state == BUSY && zero;
    assign busywait = !reset && ((state == IDLE && valid) || state == BUSY);

    dmem_latency_counter #(.W(CW)) u_counter (
        .clock     (clock),
        .reset     (reset),
        .load      (state == IDLE && valid),
        .enable    (state == BUSY),
        .load_value(CW'(LATENCY - 1)),
        .zero      (zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            readdata   <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            is_write_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (valid) begin
                    state      <= BUSY;
                    addr_q     <= address;
                    data_q     <= writedata;
                    is_write_q <= write;
                end
                BUSY: if (zero) begin
                    state <= DONE;
                    if (!is_write_q)
                        readdata <= mem[addr_q];
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_mem
        always_ff @(posedge clock) begin
            if (reset)
                mem[g] <= '0;
            else if (commit && is_write_q && addr_q == ADDR_W'(g))
                mem[g] <= data_q;
        end
    end

`ifdef DMEM_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            read_count  <= '0;
            write_count <= '0;
        end else if (commit) begin
            if (is_write_q && write_count != '1)
                write_count <= write_count + 1'b1;
            if (!is_write_q && read_count != '1)
                read_count <= read_count + 1'b1;
        end
    end
`endif
endmodule

// File: doc/param_data_memory.md
# param_data_memory

Parametrised successor of the lab data memory: a synchronous, multi-cycle main memory serving block-sized reads and writes to the data cache over a read/write/busywait handshake. Block size, block count and access latency are parameters. An explicit latency FSM replaces delay-based timing, so the block is synthesisable and cycle-exact.

## Interface
- ADDR_W, 6, block address width; depth = 2^ADDR_W blocks
- BLOCK_BYTES, 4, bytes per block; power of two, ≥ 1
- LATENCY, 5, clock edges from request accept to completion; ≥ 1
- clock  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- read  in  1  read request; held by the requester until busywait falls
- write  in  1  write request; held by the requester until busywait falls
- address  in  ADDR_W  block address
- writedata  in  8*BLOCK_BYTES  write block; byte i at bits [8i+7:8i]
- readdata  out  8*BLOCK_BYTES  last completed read block
- busywait  out  1  access pending; requester stalls while high
- read_count, write_count  out  16 each  present only with DMEM_PERF_CNT_EN

## Operation
- Storage: 2^ADDR_W × BLOCK_BYTES bytes. Byte i of a block lives at byte address {address, i}, little-endian in the bus.
- Valid request: exactly one of read and write is high. read and write both high is illegal; it is ignored and busywait stays 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY on a valid request. On the same edge: capture address, writedata and the access type; load the counter with LATENCY-1.
  - BUSY: the counter decrements each edge. When the counter is 0, the next edge moves to DONE and commits the access. A read loads readdata. A write stores the captured bytes.
  - DONE → IDLE unconditionally. A request still high during DONE is not accepted, which gives the requester one cycle to drop it.
- busywait is combinational: (IDLE && valid request) || BUSY. It is 0 in DONE and during reset.
- Captured address and data are used for the commit. Input changes after accept have no effect.
- readdata holds its value until the next read commits. Writes never alter readdata.
- Reset (synchronous, any state):
  - state → IDLE; counter → 0; readdata → 0; all memory bytes → 0.
  - A request in flight is aborted; a pending write is not committed.
  - busywait reads 0 while reset is high.
  - Counters → 0, when DMEM_PERF_CNT_EN is defined.

## Timing
- Edge 0 is the accept edge. Commit happens on edge LATENCY. busywait is high from request assertion until edge LATENCY, so a stall lasts LATENCY+1 cycles counting the accept cycle.
- DONE occupies the cycle after edge LATENCY. The earliest next accept is edge LATENCY+2.
- LATENCY=1: accept at edge 0, commit at edge 1.
- Read-after-write to the same address, issued back-to-back, returns the new data. This holds because the write commits before the read is accepted.
- Address wrap: none needed; the full ADDR_W range is valid.

## Configuration
- DMEM_PERF_CNT_EN defined:
  - Adds read_count and write_count.
  - Each increments on the commit edge of its access type and saturates at 16'hFFFF.
  - Aborted accesses do not count.
- DMEM_PERF_CNT_EN undefined: the ports and counter logic are absent; behaviour is otherwise identical.

## Structure
- Shared package dmem_pkg holds:
  - the state typedef (IDLE/BUSY/DONE)
  - default constants DMEM_ADDR_W=6, DMEM_BLOCK_BYTES=4, DMEM_LATENCY=5
  - DMEM_CNT_W=16
- One sub-module, dmem_latency_counter:
  - inputs: load (value LATENCY-1), enable, clock, reset
  - output: zero flag
- Storage and FSM live in the top module.

## Test plan
- Reset with default parameters, then read address 6'h00 → busywait high for 6 cycles; readdata = 32'h0000_0000 after edge 5.
- Write 32'hDEAD_BEEF to 6'h3F, then read 6'h3F → readdata = 32'hDEAD_BEEF. Bytes 252..255 hold EF, BE, AD, DE.
- Change writedata to 32'h1234_5678 one cycle after accept of a write of 32'hCAFE_F00D to 6'h01 → read-back gives 32'hCAFE_F00D.
- Assert reset at edge 2 of a write of 32'hFFFF_FFFF to 6'h05 → FSM returns to IDLE, busywait = 0, and a later read of 6'h05 returns 32'h0000_0000.
- Drive read=1 and write=1 together → busywait stays 0 and memory is unchanged. With DMEM_PERF_CNT_EN, both counts stay 0.
- BLOCK_BYTES=16, LATENCY=1, ADDR_W=4: write a 128-bit pattern to 4'hF, then read it back → exact match. busywait is high 2 cycles per access.
